// File: rtl/fm_dm_seq_if.sv
// Control/data bundle between the FM demodulation datapath and its sequencer.
// The master drives run control and audio; the slave returns strobes, DAC code and status.
interface fm_dm_seq_if;
    logic        enable;
    logic [11:0] audio_in;
    logic        audio_valid;
    logic        adc_en;
    logic        ds_en;
    logic        flush;
    logic [13:0] dac_data;
    logic        running;
    logic [1:0]  state;
    logic [7:0]  clip_events;

    modport master (
        output enable, audio_in, audio_valid,
        input  adc_en, ds_en, flush, dac_data, running, state, clip_events
    );

    modport slave (
        input  enable, audio_in, audio_valid,
        output adc_en, ds_en, flush, dac_data, running, state, clip_events
    );
endinterface

// File: rtl/fm_dm_seq.sv
// FM demodulation chain sequencer: ADC/decimation strobes, settle muting,
// offset-binary DAC formatting and clip-triggered flush/recovery.
module fm_dm_seq #(
    parameter int DIV        = 4,
    parameter int DECIM      = 8,
    parameter int SETTLE     = 64,
    parameter int CLIP_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    fm_dm_seq_if.slave  bus
);
    localparam int DIV_W  = $clog2(DIV);
    localparam int DEC_W  = $clog2(DECIM);
    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam int CLIP_W = $clog2(CLIP_LIMIT);
    localparam int REC_W  = $clog2(DIV * DECIM);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RUN     = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [DEC_W-1:0]    r_dec_cnt;
    logic [SET_W-1:0]    r_settle_cnt;
    logic [CLIP_W-1:0]   r_clip_cnt;
    logic [REC_W-1:0]    r_rec_cnt;
    logic                r_flush;
    logic [13:0]         r_dac_data;
    logic                r_running;
    logic [7:0]          r_clip_events;

    logic                w_adc_en;
    logic                w_ds_en;
    logic                w_clip;
    logic [13:0]         w_dac_code;

    // Strobe decode from the registered phase counters; silent in IDLE.
    always_comb begin
        w_adc_en = 1'b0;
        w_ds_en  = 1'b0;
        if (r_state != ST_IDLE) begin
            w_adc_en = (r_div_cnt == DIV_W'(DIV - 1));
            w_ds_en  = w_adc_en && (r_dec_cnt == DEC_W'(DECIM - 1));
        end else begin
            w_adc_en = 1'b0;
            w_ds_en  = 1'b0;
        end
    end

    // Full-scale detection and signed-to-offset-binary conversion of the audio sample.
    always_comb begin
        w_clip     = (bus.audio_in == 12'h7FF) || (bus.audio_in == 12'h800);
        w_dac_code = {~bus.audio_in[11], bus.audio_in[10:0], 2'b00};
    end

    // Sequencer FSM, phase counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_div_cnt     <= '0;
            r_dec_cnt     <= '0;
            r_settle_cnt  <= '0;
            r_clip_cnt    <= '0;
            r_rec_cnt     <= '0;
            r_flush       <= 1'b0;
            r_dac_data    <= 14'h2000;
            r_running     <= 1'b0;
            r_clip_events <= 8'd0;
        end else if (!bus.enable) begin
            // Dropping enable wins over every other transition; the event count survives.
            r_state      <= ST_IDLE;
            r_div_cnt    <= '0;
            r_dec_cnt    <= '0;
            r_settle_cnt <= '0;
            r_clip_cnt   <= '0;
            r_rec_cnt    <= '0;
            r_flush      <= 1'b0;
            r_dac_data   <= 14'h2000;
            r_running    <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            if (r_state != ST_IDLE) begin
                r_div_cnt <= (r_div_cnt == DIV_W'(DIV - 1)) ? '0 : r_div_cnt + DIV_W'(1);
                if (w_adc_en) begin
                    r_dec_cnt <= (r_dec_cnt == DEC_W'(DECIM - 1)) ? '0 : r_dec_cnt + DEC_W'(1);
                end
            end
            case (r_state)
                ST_IDLE: begin
                    r_state      <= ST_SETTLE;
                    r_div_cnt    <= '0;
                    r_dec_cnt    <= '0;
                    r_settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (bus.audio_valid) begin
                        if (r_settle_cnt == SET_W'(SETTLE - 1)) begin
                            r_state      <= ST_RUN;
                            r_settle_cnt <= '0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + SET_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.audio_valid) begin
                        r_dac_data <= w_dac_code;
                        r_running  <= 1'b1;
                        if (w_clip && (r_clip_cnt == CLIP_W'(CLIP_LIMIT - 1))) begin
                            // Sustained clipping: mute immediately and flush the filters.
                            r_state    <= ST_RECOVER;
                            r_clip_cnt <= '0;
                            r_rec_cnt  <= '0;
                            r_flush    <= 1'b1;
                            r_dac_data <= 14'h2000;
                            r_running  <= 1'b0;
                            if (r_clip_events != 8'hFF) begin
                                r_clip_events <= r_clip_events + 8'd1;
                            end
                        end else if (w_clip) begin
                            r_clip_cnt <= r_clip_cnt + CLIP_W'(1);
                        end else begin
                            r_clip_cnt <= '0;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (r_rec_cnt == REC_W'(DIV * DECIM - 1)) begin
                        r_state      <= ST_SETTLE;
                        r_rec_cnt    <= '0;
                        r_settle_cnt <= '0;
                    end else begin
                        r_rec_cnt <= r_rec_cnt + REC_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.adc_en      = w_adc_en;
    assign bus.ds_en       = w_ds_en;
    assign bus.flush       = r_flush;
    assign bus.dac_data    = r_dac_data;
    assign bus.running     = r_running;
    assign bus.state       = r_state;
    assign bus.clip_events = r_clip_events;
endmodule

// File: tb/tb_fm_dm_seq.sv
// Directed bench for fm_dm_seq: strobes, settling, formatting, clip recovery,
// enable drop and mid-run reset, each with hand-computed expectations.
module tb_fm_dm_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fm_dm_seq_if bus();

    fm_dm_seq #(.DIV(4), .DECIM(8), .SETTLE(64), .CLIP_LIMIT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One valid sample on the next rising edge; returns at the following falling edge.
    task automatic send(input logic [11:0] v);
        bus.audio_valid = 1'b1;
        bus.audio_in    = v;
        @(negedge clk);
        bus.audio_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.audio_valid = 1'b0;
        bus.audio_in = 12'h000;
        repeat (3) @(negedge clk);
        checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        checks++; if (bus.adc_en !== 1'b0 || bus.ds_en !== 1'b0 || bus.flush !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b%b exp=000", bus.adc_en, bus.ds_en, bus.flush); end
        checks++; if (bus.dac_data !== 14'h2000) begin failures++; $display("FAIL reset_dac got=%h exp=2000", bus.dac_data); end
        checks++; if (bus.running !== 1'b0 || bus.clip_events !== 8'd0) begin failures++; $display("FAIL reset_status got=%b/%0d exp=0/0", bus.running, bus.clip_events); end
    endtask

    task automatic test_strobes();
        rst_n = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            checks++; if (bus.adc_en !== ((c % 4) == 0)) begin failures++; $display("FAIL adc_en c=%0d got=%b exp=%b", c, bus.adc_en, (c % 4) == 0); end
            checks++; if (bus.ds_en !== ((c % 32) == 0)) begin failures++; $display("FAIL ds_en c=%0d got=%b exp=%b", c, bus.ds_en, (c % 32) == 0); end
            checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL strobe_state c=%0d got=%0d exp=1", c, bus.state); end
        end
    endtask

    task automatic test_settle();
        for (int i = 1; i <= 64; i++) begin
            send(12'h100);
            checks++; if (bus.dac_data !== 14'h2000 || bus.running !== 1'b0) begin failures++; $display("FAIL settle_mute i=%0d got=%h/%b exp=2000/0", i, bus.dac_data, bus.running); end
            checks++; if (bus.state !== ((i == 64) ? 2'd2 : 2'd1)) begin failures++; $display("FAIL settle_state i=%0d got=%0d", i, bus.state); end
        end
        send(12'h100);
        checks++; if (bus.dac_data !== 14'h2400) begin failures++; $display("FAIL first_out got=%h exp=2400", bus.dac_data); end
        checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL unmute got=%b exp=1", bus.running); end
        repeat (3) @(negedge clk);
        checks++; if (bus.dac_data !== 14'h2400) begin failures++; $display("FAIL dac_hold got=%h exp=2400", bus.dac_data); end
    endtask

    task automatic test_clip_format();
        send(12'h800);
        checks++; if (bus.dac_data !== 14'h0000) begin failures++; $display("FAIL fmt_neg_fs got=%h exp=0000", bus.dac_data); end
        send(12'h7FF);
        checks++; if (bus.dac_data !== 14'h3FFC) begin failures++; $display("FAIL fmt_pos_fs got=%h exp=3ffc", bus.dac_data); end
        send(12'h100);
        for (int i = 1; i <= 15; i++) begin
            send(12'h7FF);
            checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL clip15a i=%0d got=%0d exp=2", i, bus.state); end
        end
        send(12'h123);
        checks++; if (bus.dac_data !== 14'h248C) begin failures++; $display("FAIL fmt_mid got=%h exp=248c", bus.dac_data); end
        for (int i = 1; i <= 15; i++) begin
            send(12'h800);
            checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL clip15b i=%0d got=%0d exp=2", i, bus.state); end
        end
        checks++; if (bus.dac_data !== 14'h0000) begin failures++; $display("FAIL clip_output got=%h exp=0000", bus.dac_data); end
        send(12'h7FE);
        checks++; if (bus.dac_data !== 14'h3FF8 || bus.clip_events !== 8'd0) begin failures++; $display("FAIL near_fs got=%h/%0d exp=3ff8/0", bus.dac_data, bus.clip_events); end
    endtask

    task automatic test_recovery();
        int n_adc;
        int n_ds;
        for (int i = 1; i <= 16; i++) begin
            send(12'h7FF);
            if (i < 16) begin
                checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL pre_recover i=%0d got=%0d exp=2", i, bus.state); end
            end
        end
        checks++; if (bus.state !== 2'd3 || bus.flush !== 1'b1) begin failures++; $display("FAIL recover_entry got=%0d/%b exp=3/1", bus.state, bus.flush); end
        checks++; if (bus.dac_data !== 14'h2000 || bus.running !== 1'b0) begin failures++; $display("FAIL recover_mute got=%h/%b exp=2000/0", bus.dac_data, bus.running); end
        checks++; if (bus.clip_events !== 8'd1) begin failures++; $display("FAIL clip_events1 got=%0d exp=1", bus.clip_events); end
        n_adc = 0;
        n_ds  = 0;
        for (int k = 1; k <= 32; k++) begin
            if (k > 1) @(negedge clk);
            checks++; if (bus.state !== 2'd3) begin failures++; $display("FAIL recover_len k=%0d got=%0d exp=3", k, bus.state); end
            if (k == 2) begin
                checks++; if (bus.flush !== 1'b0) begin failures++; $display("FAIL flush_one_cycle got=%b exp=0", bus.flush); end
            end
            n_adc += int'(bus.adc_en);
            n_ds  += int'(bus.ds_en);
            bus.audio_in    = 12'h7FF;
            bus.audio_valid = (k < 32);
        end
        @(negedge clk);
        checks++; if (bus.state !== 2'd1 || bus.dac_data !== 14'h2000) begin failures++; $display("FAIL recover_exit got=%0d/%h exp=1/2000", bus.state, bus.dac_data); end
        checks++; if (n_adc != 8 || n_ds != 1) begin failures++; $display("FAIL recover_strobes got=%0d/%0d exp=8/1", n_adc, n_ds); end
        for (int i = 1; i <= 64; i++) begin
            send(12'h200);
            checks++; if (bus.state !== ((i == 64) ? 2'd2 : 2'd1) || bus.dac_data !== 14'h2000) begin failures++; $display("FAIL resettle i=%0d got=%0d/%h", i, bus.state, bus.dac_data); end
        end
        send(12'h200);
        checks++; if (bus.dac_data !== 14'h2800 || bus.running !== 1'b1) begin failures++; $display("FAIL re_unmute got=%h/%b exp=2800/1", bus.dac_data, bus.running); end
    endtask

    task automatic test_enable_drop();
        int n;
        for (int i = 1; i <= 16; i++) send(12'h7FF);
        checks++; if (bus.state !== 2'd3 || bus.clip_events !== 8'd2) begin failures++; $display("FAIL second_recover got=%0d/%0d exp=3/2", bus.state, bus.clip_events); end
        repeat (5) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL drop_recover_state got=%0d exp=0", bus.state); end
        checks++; if (bus.adc_en !== 1'b0 || bus.ds_en !== 1'b0 || bus.flush !== 1'b0) begin failures++; $display("FAIL drop_strobes got=%b%b%b exp=000", bus.adc_en, bus.ds_en, bus.flush); end
        checks++; if (bus.dac_data !== 14'h2000 || bus.running !== 1'b0 || bus.clip_events !== 8'd2) begin failures++; $display("FAIL drop_outputs got=%h/%b/%0d exp=2000/0/2", bus.dac_data, bus.running, bus.clip_events); end
        n = 0;
        repeat (8) begin
            @(negedge clk);
            n += int'(bus.adc_en) + int'(bus.ds_en);
        end
        checks++; if (n != 0 || bus.state !== 2'd0) begin failures++; $display("FAIL idle_quiet got=%0d/%0d exp=0/0", n, bus.state); end
        bus.enable = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (bus.adc_en !== (c == 4) || bus.state !== 2'd1) begin failures++; $display("FAIL reenable c=%0d got=%b/%0d", c, bus.adc_en, bus.state); end
        end
        repeat (10) send(12'h100);
        checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL mid_settle got=%0d exp=1", bus.state); end
        bus.enable      = 1'b0;
        bus.audio_valid = 1'b1;
        bus.audio_in    = 12'h100;
        @(negedge clk);
        bus.audio_valid = 1'b0;
        checks++; if (bus.state !== 2'd0 || bus.dac_data !== 14'h2000 || bus.clip_events !== 8'd2) begin failures++; $display("FAIL drop_settle got=%0d/%h/%0d exp=0/2000/2", bus.state, bus.dac_data, bus.clip_events); end
        bus.enable = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 64; i++) begin
            send(12'h100);
            if (i >= 63) begin
                checks++; if (bus.state !== ((i == 64) ? 2'd2 : 2'd1)) begin failures++; $display("FAIL settle_cleared i=%0d got=%0d", i, bus.state); end
            end
        end
        send(12'h7FE);
        checks++; if (bus.dac_data !== 14'h3FF8 || bus.running !== 1'b1) begin failures++; $display("FAIL run_again got=%h/%b exp=3ff8/1", bus.dac_data, bus.running); end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 1; i <= 16; i++) send(12'h7FF);
        checks++; if (bus.clip_events !== 8'd3) begin failures++; $display("FAIL clip_events3 got=%0d exp=3", bus.clip_events); end
        repeat (32) @(negedge clk);
        checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL third_settle got=%0d exp=1", bus.state); end
        repeat (64) send(12'h100);
        send(12'h001);
        checks++; if (bus.dac_data !== 14'h2004 || bus.state !== 2'd2) begin failures++; $display("FAIL pre_reset_run got=%h/%0d exp=2004/2", bus.dac_data, bus.state); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.state !== 2'd0 || bus.dac_data !== 14'h2000 || bus.running !== 1'b0) begin failures++; $display("FAIL midreset_state got=%0d/%h/%b exp=0/2000/0", bus.state, bus.dac_data, bus.running); end
        checks++; if (bus.adc_en !== 1'b0 || bus.ds_en !== 1'b0 || bus.flush !== 1'b0) begin failures++; $display("FAIL midreset_strobes got=%b%b%b exp=000", bus.adc_en, bus.ds_en, bus.flush); end
        checks++; if (bus.clip_events !== 8'd0) begin failures++; $display("FAIL midreset_events got=%0d exp=0", bus.clip_events); end
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_strobes();
        test_settle();
        test_clip_format();
        test_recovery();
        test_enable_drop();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
